// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion, flush/hold and bubble counter
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall_in,
    input  logic              clr_count,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    input  logic              id_uses1,
    input  logic              id_uses2,
    input  logic [REG_W-1:0]  id_dst,
    input  logic [DATA_W-1:0] id_data1,
    input  logic [DATA_W-1:0] id_data2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [3:0]        id_aluop,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_src1,
    output logic [REG_W-1:0]  ex_src2,
    output logic [REG_W-1:0]  ex_dst,
    output logic [DATA_W-1:0] ex_data1,
    output logic [DATA_W-1:0] ex_data2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [3:0]        ex_aluop,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  bubble_count
);

    logic              valid_q, valid_d;
    logic [REG_W-1:0]  src1_q, src1_d, src2_q, src2_d, dst_q, dst_d;
    logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d, imm_q, imm_d;
    logic [3:0]        aluop_q, aluop_d;
    logic              regwrite_q, regwrite_d, memread_q, memread_d, memwrite_q, memwrite_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              load_use, bubble, zero, capture;

    // Hazard detection against the load in EX and the per-edge action select
    always_comb begin
        load_use     = id_valid & valid_q & memread_q &
                       ((id_uses1 & (id_src1 == dst_q)) | (id_uses2 & (id_src2 == dst_q)));
        hazard_stall = load_use & ~flush;
        bubble       = ~flush & ~stall_in & load_use;
        zero         = flush | bubble;
        capture      = ~flush & ~stall_in & ~load_use;
    end

    // Next EX state: squash on flush/bubble, hold on stall_in, otherwise capture decode
    always_comb begin
        valid_d    = zero ? 1'b0       : capture ? id_valid                  : valid_q;
        src1_d     = zero ? '0         : capture ? id_src1                   : src1_q;
        src2_d     = zero ? '0         : capture ? id_src2                   : src2_q;
        dst_d      = zero ? '0         : capture ? id_dst                    : dst_q;
        data1_d    = zero ? '0         : capture ? id_data1                  : data1_q;
        data2_d    = zero ? '0         : capture ? id_data2                  : data2_q;
        imm_d      = zero ? '0         : capture ? id_imm                    : imm_q;
        aluop_d    = zero ? 4'd0       : capture ? id_aluop                  : aluop_q;
        regwrite_d = zero ? 1'b0       : capture ? id_valid & id_regwrite    : regwrite_q;
        memread_d  = zero ? 1'b0       : capture ? id_valid & id_memread     : memread_q;
        memwrite_d = zero ? 1'b0       : capture ? id_valid & id_memwrite    : memwrite_q;
        count_d    = clr_count ? '0 :
                     (bubble && count_q != {CNT_W{1'b1}}) ? count_q + 1'b1 : count_q;
    end

    // EX registers and bubble counter, cleared asynchronously while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            src1_q     <= '0;
            src2_q     <= '0;
            dst_q      <= '0;
            data1_q    <= '0;
            data2_q    <= '0;
            imm_q      <= '0;
            aluop_q    <= 4'd0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            count_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            dst_q      <= dst_d;
            data1_q    <= data1_d;
            data2_q    <= data2_d;
            imm_q      <= imm_d;
            aluop_q    <= aluop_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            count_q    <= count_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_src1      = src1_q;
    assign ex_src2      = src2_q;
    assign ex_dst       = dst_q;
    assign ex_data1     = data1_q;
    assign ex_data2     = data2_q;
    assign ex_imm       = imm_q;
    assign ex_aluop     = aluop_q;
    assign ex_regwrite  = regwrite_q;
    assign ex_memread   = memread_q;
    assign ex_memwrite  = memwrite_q;
    assign bubble_count = count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector bench for id_ex_stage with a 4-bit bubble counter
module tb_id_ex_stage;

    logic        clk = 1'b0, rst = 1'b0;
    logic        flush = 0, stall_in = 0, clr_count = 0, id_valid = 0;
    logic [3:0]  id_src1 = 0, id_src2 = 0, id_dst = 0, id_aluop = 0;
    logic        id_uses1 = 0, id_uses2 = 0, id_regwrite = 0, id_memread = 0, id_memwrite = 0;
    logic [15:0] id_data1 = 0, id_data2 = 0, id_imm = 0;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, hazard_stall;
    logic [3:0]  ex_src1, ex_src2, ex_dst, ex_aluop, bubble_count;
    logic [15:0] ex_data1, ex_data2, ex_imm;

    int n_cmp = 0, n_fail = 0;

    id_ex_stage #(.DATA_W(16), .REG_W(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in), .clr_count(clr_count),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_uses1(id_uses1), .id_uses2(id_uses2), .id_dst(id_dst),
        .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm), .id_aluop(id_aluop),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .ex_valid(ex_valid), .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dst(ex_dst),
        .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_aluop(ex_aluop),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .hazard_stall(hazard_stall), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        fl, st, cl, v;
        logic [3:0]  s1, s2;
        logic        u1, u2;
        logic [3:0]  dst;
        logic [15:0] d1, d2;
        logic        mr, rw, mw;
        logic        hz, ev;
        logic [3:0]  edst;
        logic [15:0] ed1, ed2;
        logic        erw, emr, emw;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] s1, input logic u1, input logic [3:0] s2,
                         input logic u2, input logic [3:0] dst, input logic [15:0] d1,
                         input logic [15:0] d2, input logic mr, input logic rw, input logic mw);
        id_valid = v; id_src1 = s1; id_uses1 = u1; id_src2 = s2; id_uses2 = u2; id_dst = dst;
        id_data1 = d1; id_data2 = d2; id_imm = d1 + d2; id_aluop = dst;
        id_memread = mr; id_regwrite = rw; id_memwrite = mw;
    endtask

    initial begin
        //           fl st cl v  s1 s2 u1 u2 dst d1        d2        mr rw mw | hz ev edst ed1      ed2      erw emr emw cnt
        vecs[0]  = '{0, 0, 0, 1, 0, 0, 0, 0, 3, 16'h1234, 16'hBEEF, 0, 1, 0,   0, 1, 3, 16'h1234, 16'hBEEF, 1, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 1, 1, 0, 1, 0, 5, 16'h0011, 16'h0022, 1, 1, 0,   0, 1, 5, 16'h0011, 16'h0022, 1, 1, 0, 0};
        vecs[2]  = '{0, 0, 0, 1, 2, 5, 1, 1, 6, 16'h0066, 16'h0077, 0, 1, 0,   1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1};
        vecs[3]  = '{0, 0, 0, 1, 2, 5, 1, 1, 6, 16'h0066, 16'h0077, 0, 1, 0,   0, 1, 6, 16'h0066, 16'h0077, 1, 0, 0, 1};
        vecs[4]  = '{0, 0, 0, 1, 0, 0, 0, 0, 5, 16'h0001, 16'h0002, 1, 1, 0,   0, 1, 5, 16'h0001, 16'h0002, 1, 1, 0, 1};
        vecs[5]  = '{0, 0, 0, 1, 7, 5, 1, 0, 8, 16'h0088, 16'h0099, 0, 1, 0,   0, 1, 8, 16'h0088, 16'h0099, 1, 0, 0, 1};
        vecs[6]  = '{0, 0, 0, 1, 0, 0, 0, 0, 4, 16'h0044, 16'h0045, 1, 1, 0,   0, 1, 4, 16'h0044, 16'h0045, 1, 1, 0, 1};
        vecs[7]  = '{1, 0, 0, 1, 4, 0, 1, 0, 9, 16'h0099, 16'h00AA, 0, 0, 1,   0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0,10, 16'h0BAD, 16'hCAFE, 1, 1, 1,   0, 0,10, 16'h0BAD, 16'hCAFE, 0, 0, 0, 1};
        vecs[9]  = '{0, 0, 0, 1, 0, 0, 0, 0, 2, 16'h00AA, 16'h0000, 1, 1, 0,   0, 1, 2, 16'h00AA, 16'h0000, 1, 1, 0, 1};
        vecs[10] = '{0, 1, 0, 1, 2, 0, 1, 0, 3, 16'h5555, 16'h0001, 0, 1, 0,   1, 1, 2, 16'h00AA, 16'h0000, 1, 1, 0, 1};
        vecs[11] = '{0, 0, 0, 1, 2, 0, 1, 0, 3, 16'h5555, 16'h0001, 0, 1, 0,   1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 2};
        vecs[12] = '{0, 0, 0, 1, 2, 0, 1, 0, 3, 16'h5555, 16'h0001, 0, 1, 0,   0, 1, 3, 16'h5555, 16'h0001, 1, 0, 0, 2};
        vecs[13] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0,   0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0};

        #2;
        chk("por_valid", ex_valid, 0);
        chk("por_count", bubble_count, 0);
        #10 rst = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            flush = vecs[i].fl; stall_in = vecs[i].st; clr_count = vecs[i].cl;
            drive(vecs[i].v, vecs[i].s1, vecs[i].u1, vecs[i].s2, vecs[i].u2, vecs[i].dst,
                  vecs[i].d1, vecs[i].d2, vecs[i].mr, vecs[i].rw, vecs[i].mw);
            #1;
            chk($sformatf("v%0d_hazard", i), hazard_stall, vecs[i].hz);
            tick();
            chk($sformatf("v%0d_valid", i), ex_valid, vecs[i].ev);
            chk($sformatf("v%0d_dst", i), ex_dst, vecs[i].edst);
            chk($sformatf("v%0d_aluop", i), ex_aluop, vecs[i].edst);
            chk($sformatf("v%0d_data1", i), ex_data1, vecs[i].ed1);
            chk($sformatf("v%0d_data2", i), ex_data2, vecs[i].ed2);
            chk($sformatf("v%0d_imm", i), ex_imm, vecs[i].ed1 + vecs[i].ed2);
            chk($sformatf("v%0d_regwrite", i), ex_regwrite, vecs[i].erw);
            chk($sformatf("v%0d_memread", i), ex_memread, vecs[i].emr);
            chk($sformatf("v%0d_memwrite", i), ex_memwrite, vecs[i].emw);
            chk($sformatf("v%0d_count", i), bubble_count, vecs[i].cnt);
        end
        flush = 0; stall_in = 0; clr_count = 0;

        // self-dependent load: one bubble every two cycles
        drive(1, 1, 1, 0, 0, 1, 16'h0010, 16'h0020, 1, 1, 0);
        tick();
        chk("sat_load_in_ex", ex_memread, 1);
        for (int i = 1; i <= 17; i++) begin
            tick();
            tick();
            if (i == 15) chk("sat_reach_f", bubble_count, 4'hF);
        end
        chk("sat_hold_f", bubble_count, 4'hF);
        clr_count = 1;
        #1;
        chk("clr_hazard", hazard_stall, 1);
        tick();
        chk("clr_count", bubble_count, 0);
        chk("clr_bubble_valid", ex_valid, 0);
        clr_count = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            tick();
        end
        chk("pre_rst_count", bubble_count, 5);
        chk("pre_rst_valid", ex_valid, 1);
        chk("pre_rst_regwrite", ex_regwrite, 1);

        // asynchronous reset mid-cycle
        drive(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", ex_valid, 0);
        chk("arst_regwrite", ex_regwrite, 0);
        chk("arst_memread", ex_memread, 0);
        chk("arst_dst", ex_dst, 0);
        chk("arst_data1", ex_data1, 0);
        chk("arst_count", bubble_count, 0);
        #1 rst = 1'b1;
        tick();

        // stall_in hold for three cycles, then release
        drive(1, 9, 0, 12, 0, 7, 16'h00AA, 16'h0003, 0, 1, 0);
        tick();
        chk("hold_load_data1", ex_data1, 16'h00AA);
        stall_in = 1;
        id_data1 = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold_c%0d_data1", i), ex_data1, 16'h00AA);
        end
        stall_in = 0;
        tick();
        chk("release_data1", ex_data1, 16'h5555);
        chk("release_src1", ex_src1, 9);
        chk("release_src2", ex_src2, 12);
        chk("release_count", bubble_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode (register file read) and execute in the 16-bit pipelined CPU.
- Captures the two source operands and the decoded control for one instruction per cycle.
- Detects load-use hazards against the instruction currently in EX and inserts one bubble for each.
- Supports a downstream hold (stall_in) and a branch squash (flush).
- Counts inserted bubbles for performance debug.
- Writeback-to-decode forwarding is already handled by the register file write-through, so this block does not handle it.

Parameters:
- DATA_W, 16, operand/immediate width
- REG_W, 4, register index width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- flush  in  1  squash the instruction entering EX (taken branch)
- stall_in  in  1  downstream hold; freeze all EX registers
- clr_count  in  1  synchronous clear of bubble_count
- id_valid  in  1  decode slot holds a real instruction
- id_src1, id_src2  in  REG_W  source register ids
- id_uses1, id_uses2  in  1  instruction actually reads src1/src2
- id_dst  in  REG_W  destination register id
- id_data1, id_data2  in  DATA_W  operands from register file read ports
- id_imm  in  DATA_W  sign-extended immediate
- id_aluop  in  4  ALU operation code
- id_regwrite, id_memread, id_memwrite  in  1  decoded control
- ex_valid  out  1  EX slot holds a real instruction
- ex_src1, ex_src2, ex_dst  out  REG_W  registered ids
- ex_data1, ex_data2, ex_imm  out  DATA_W  registered operands/immediate
- ex_aluop  out  4  registered ALU op
- ex_regwrite, ex_memread, ex_memwrite  out  1  registered control
- hazard_stall  out  1  hold PC and IF/ID this cycle (combinational)
- bubble_count  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (rst=0, asynchronous): every ex_* output = 0 and bubble_count = 0. Takes effect immediately, mid-stall or mid-flush. The first capture occurs on the first rising edge after rst returns to 1.
- Load-use condition (combinational): load_use = id_valid & ex_valid & ex_memread & ((id_uses1 & id_src1==ex_dst) | (id_uses2 & id_src2==ex_dst)).
  - A source with uses=0 never matches.
  - ex_dst==0 is not special-cased.
- hazard_stall = load_use & ~flush.
- On each rising edge the first matching rule applies:
  1. flush=1: ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_aluop = 0. Data/id fields = 0.
  2. stall_in=1: all ex_* hold their values.
  3. load_use=1: bubble; same zeroing as flush.
  4. Otherwise: capture all id_* into ex_*. If id_valid=0, ex_regwrite/ex_memread/ex_memwrite = 0 regardless of inputs.
- Latency: 1 cycle from id_* to ex_*.
- After a bubble, ex_memread=0, so load_use deasserts next cycle. The held decode instruction then enters EX, giving exactly one bubble per load-use pair.
- Bubble counter:
  - clr_count=1 sets it to 0 (priority over increment).
  - It increments only on edges where rule 3 fires. Flush and stall_in cycles do not count.
  - Saturates at 2^CNT_W-1 with no wrap.
- Simultaneous events:
  - flush with load_use: flush wins, hazard_stall=0, no count.
  - stall_in with load_use: hold, hazard_stall=1, no count.

Test Plan:
1. Reset: drive rst=0 mid-run with ex_valid=1, ex_regwrite=1, bubble_count=5 -> all ex_* = 0 and bubble_count = 0 immediately, before the next clk edge.
2. Pass-through: id_valid=1, id_data1=0x1234, id_data2=0xBEEF, id_dst=3, id_regwrite=1 -> on the next edge ex_data1=0x1234, ex_data2=0xBEEF, ex_dst=3, ex_regwrite=1, hazard_stall=0.
3. Load-use: EX holds a load (ex_memread=1, ex_dst=5); ID has id_src2=5, id_uses2=1.
   - hazard_stall=1 and ex_valid=0 after the edge; bubble_count 0->1.
   - Next edge: the ID instruction is in EX and hazard_stall=0.
   - Repeat with id_uses2=0 -> no stall.
4. Flush priority: load_use condition active together with flush=1 -> hazard_stall=0, ex_valid=0, ex_memwrite=0, bubble_count unchanged.
5. Stall hold: ex_data1=0x00AA with stall_in=1 for 3 cycles while id_data1 changes to 0x5555 -> ex_data1 stays 0x00AA. Release stall_in -> ex_data1=0x5555 after the next edge.
6. Counter: with CNT_W=4 (override), force 17 load-use bubbles -> bubble_count saturates at 0xF. Then clr_count=1 together with a bubble -> 0.
